// File: rtl/calc_ctrl_pkg.sv
// Shared types and opcode constants for the calculator control unit.
package calc_ctrl_pkg;

  // Controller sequencing states.
  typedef enum logic [2:0] {
    IDLE,
    GET_A,
    GET_OP,
    GET_B,
    WAIT_START,
    EXEC,
    SHOW,
    ERR
  } state_t;

  // Opcodes of the standard four-function operator set.
  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_MUL = 2;
  localparam int OP_DIV = 3;

endpackage

// File: rtl/calc_ctrl_chain_btn_event.sv
// Button sampler: a shared tick counter plus per-button sample/edge
// registers. A one-cycle event is produced for each 0->1 change seen
// between two consecutive tick samples.
module btn_event #(
  parameter int TICK_DIV = 100000,
  parameter int W        = 1
) (
  input  logic         Clock,
  input  logic         ClearAll,
  input  logic [W-1:0] buttons,
  output logic [W-1:0] events
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] tick_cnt_reg;
  logic             tick;
  logic [W-1:0]     sample_reg;
  logic [W-1:0]     event_reg;

  assign tick = (tick_cnt_reg == CNT_W'(TICK_DIV - 1));

  // Free-running tick counter, wrapping at TICK_DIV-1.
  always_ff @(posedge Clock) begin
    if (!ClearAll) begin
      tick_cnt_reg <= '0;
    end else if (tick) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + CNT_W'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_btn
      // Sample on tick; flag a rising edge for exactly one cycle.
      always_ff @(posedge Clock) begin
        if (!ClearAll) begin
          sample_reg[gi] <= 1'b0;
          event_reg[gi]  <= 1'b0;
        end else if (tick) begin
          sample_reg[gi] <= buttons[gi];
          event_reg[gi]  <= buttons[gi] & ~sample_reg[gi];
        end else begin
          event_reg[gi]  <= 1'b0;
        end
      end
    end
  endgenerate

  assign events = event_reg;

endmodule

// File: rtl/calc_ctrl_chain.sv
// Calculator control unit with operation chaining, divide-by-zero error
// state and ClearEntry recovery. All strobes are registered one-cycle
// pulses in the system clock domain.
module calc_ctrl_chain
  import calc_ctrl_pkg::*;
#(
  parameter int TICK_DIV  = 100000,
  parameter int NUM_OPS   = 4,
  parameter int OP_W      = $clog2(NUM_OPS),
  parameter int DIV_OP    = OP_DIV,
  parameter int MAX_CHAIN = 8
) (
  input  logic                           Clock,
  input  logic                           ClearAll,
  input  logic                           Enter,
  input  logic                           Start,
  input  logic                           ClearEntry,
  input  logic [NUM_OPS-1:0]             OpReq,
  input  logic                           DivZero,
  output logic                           LoadA,
  output logic                           LoadB,
  output logic                           LoadResult,
  output logic                           LoadOU,
  output logic                           ResultToA,
  output logic                           IU_AU,
  output logic [OP_W-1:0]                Op,
  output logic [$clog2(MAX_CHAIN+1)-1:0] ChainCount,
  output logic                           Error
);

  localparam int CC_W   = $clog2(MAX_CHAIN + 1);
  localparam int NB     = NUM_OPS + 3;
  localparam int EV_EN  = 0;
  localparam int EV_ST  = 1;
  localparam int EV_CE  = 2;
  localparam int EV_OP0 = 3;

  logic [NB-1:0]      btn_vec;
  logic [NB-1:0]      evt_vec;
  logic               ce_ev, start_ev, enter_ev, op_ev;
  logic [OP_W-1:0]    op_idx;

  state_t             state_reg, state_next;
  logic [OP_W-1:0]    op_reg, op_next;
  logic [CC_W-1:0]    chain_reg, chain_next;
  logic               iu_au_reg, iu_au_next;
  logic               error_reg, error_next;
  logic               load_a_reg, load_a_next;
  logic               load_b_reg, load_b_next;
  logic               load_result_reg, load_result_next;
  logic               load_ou_reg, load_ou_next;
  logic               result_to_a_reg, result_to_a_next;

  assign btn_vec = {OpReq, ClearEntry, Start, Enter};

  btn_event #(
    .TICK_DIV (TICK_DIV),
    .W        (NB)
  ) u_btn_event (
    .Clock    (Clock),
    .ClearAll (ClearAll),
    .buttons  (btn_vec),
    .events   (evt_vec)
  );

  // Keep only the highest-priority event; lowest operator index wins.
  always_comb begin
    ce_ev    = evt_vec[EV_CE];
    start_ev = evt_vec[EV_ST] & ~ce_ev;
    enter_ev = evt_vec[EV_EN] & ~ce_ev & ~start_ev;
    op_ev    = (|evt_vec[NB-1:EV_OP0]) & ~ce_ev & ~start_ev & ~enter_ev;
    op_idx   = '0;
    for (int i = NUM_OPS - 1; i >= 0; i--) begin
      if (evt_vec[EV_OP0 + i]) op_idx = OP_W'(i);
    end
  end

  // State and registered outputs; active-low synchronous clear.
  always_ff @(posedge Clock) begin
    if (!ClearAll) begin
      state_reg       <= IDLE;
      op_reg          <= '0;
      chain_reg       <= '0;
      iu_au_reg       <= 1'b0;
      error_reg       <= 1'b0;
      load_a_reg      <= 1'b0;
      load_b_reg      <= 1'b0;
      load_result_reg <= 1'b0;
      load_ou_reg     <= 1'b0;
      result_to_a_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      op_reg          <= op_next;
      chain_reg       <= chain_next;
      iu_au_reg       <= iu_au_next;
      error_reg       <= error_next;
      load_a_reg      <= load_a_next;
      load_b_reg      <= load_b_next;
      load_result_reg <= load_result_next;
      load_ou_reg     <= load_ou_next;
      result_to_a_reg <= result_to_a_next;
    end
  end

  // Next-state and next-output decode; unconsumed events are dropped.
  always_comb begin
    state_next       = state_reg;
    op_next          = op_reg;
    chain_next       = chain_reg;
    iu_au_next       = iu_au_reg;
    error_next       = error_reg;
    load_a_next      = 1'b0;
    load_b_next      = 1'b0;
    load_result_next = 1'b0;
    load_ou_next     = 1'b0;
    result_to_a_next = 1'b0;
    unique case (state_reg)
      IDLE: state_next = GET_A;
      GET_A: begin
        if (enter_ev) begin
          load_a_next  = 1'b1;
          load_ou_next = 1'b1;
          iu_au_next   = 1'b0;
          state_next   = GET_OP;
        end
      end
      GET_OP: begin
        if (ce_ev) begin
          state_next = GET_A;
        end else if (op_ev) begin
          op_next    = op_idx;
          state_next = GET_B;
        end
      end
      GET_B: begin
        if (enter_ev) begin
          load_b_next  = 1'b1;
          load_ou_next = 1'b1;
          state_next   = WAIT_START;
        end
      end
      WAIT_START: begin
        if (ce_ev) begin
          state_next = GET_B;
        end else if (start_ev) begin
          if (op_reg == OP_W'(DIV_OP) && DivZero) begin
            error_next = 1'b1;
            state_next = ERR;
          end else begin
            state_next = EXEC;
          end
        end
      end
      EXEC: begin
        load_result_next = 1'b1;
        iu_au_next       = 1'b1;
        chain_next       = chain_reg + CC_W'(1);
        state_next       = SHOW;
      end
      SHOW: begin
        // LoadResult is high only on the first SHOW cycle: refresh display.
        if (load_result_reg) load_ou_next = 1'b1;
        if (ce_ev || enter_ev) begin
          chain_next = '0;
          iu_au_next = 1'b0;
          state_next = GET_A;
        end else if (op_ev && (chain_reg < CC_W'(MAX_CHAIN))) begin
          load_a_next      = 1'b1;
          result_to_a_next = 1'b1;
          op_next          = op_idx;
          iu_au_next       = 1'b0;
          state_next       = GET_B;
        end
      end
      ERR: begin
        iu_au_next = 1'b0;
        if (ce_ev || enter_ev) begin
          error_next = 1'b0;
          chain_next = '0;
          state_next = GET_A;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign LoadA      = load_a_reg;
  assign LoadB      = load_b_reg;
  assign LoadResult = load_result_reg;
  assign LoadOU     = load_ou_reg;
  assign ResultToA  = result_to_a_reg;
  assign IU_AU      = iu_au_reg;
  assign Op         = op_reg;
  assign ChainCount = chain_reg;
  assign Error      = error_reg;

endmodule

// File: doc/calc_ctrl_chain.md
Name: calc_ctrl_chain

Overview:
- Parametrised next-generation control unit for the eight-bit calculator.
- Sequences operand A, operator, operand B, Start, then result display, and drives datapath load strobes and the operator select.
- Adds over the first-generation controller:
  - operation chaining, where the result becomes the next A;
  - a generic operator count;
  - divide-by-zero error state;
  - ClearEntry recovery;
  - one-cycle strobes in the system clock domain, using an internal sampling tick instead of a divided clock.

Parameters:
- TICK_DIV, 100000: Clock cycles per button-sampling tick (>=2).
- NUM_OPS, 4: number of operator buttons and opcodes (>=2).
- OP_W, $clog2(NUM_OPS): opcode width (derived; do not override).
- DIV_OP, 3: opcode whose execution is blocked when DivZero=1.
- MAX_CHAIN, 8: maximum chained operations per calculation (>=1).

Ports:
- Clock  in  1  system clock.
- ClearAll  in  1  synchronous active-low reset.
- Enter  in  1  raw button, commits current operand.
- Start  in  1  raw button, executes.
- ClearEntry  in  1  raw button, discards current entry.
- OpReq  in  NUM_OPS  raw operator buttons; bit i selects opcode i.
- DivZero  in  1  datapath flag, B==0; level, valid whenever B is loaded.
- LoadA  out  1  load A register (both nibbles).
- LoadB  out  1  load B register.
- LoadResult  out  1  load result register.
- LoadOU  out  1  refresh output/display unit.
- ResultToA  out  1  A-mux selects result instead of input unit; qualifies LoadA.
- IU_AU  out  1  display source: 0 input unit, 1 arithmetic unit.
- Op  out  OP_W  current operator.
- ChainCount  out  $clog2(MAX_CHAIN+1)  operations completed in this calculation.
- Error  out  1  divide-by-zero error latched.

Behaviour:
- Reset: one clock and one reset. Reset is synchronous and active-low: ClearAll=0 sampled at a Clock edge. All outputs go to 0, state=IDLE, tick counter=0, button sample registers=0. Reset overrides everything, including mid-operation.
- Tick: counter counts 0..TICK_DIV-1 and wraps; tick=1 on the cycle the counter equals TICK_DIV-1.
- Button sampling: on a tick cycle every button is sampled. An event is a 0->1 change versus the previous sample; the event is valid for exactly that one Clock cycle.
- Held button: a button held through reset release gives one event at the first tick. Holding longer gives no repeat.
- Strobes: LoadA, LoadB, LoadResult, LoadOU and ResultToA are registered one-Clock-cycle pulses, asserted the cycle after the triggering event. They default to 0.
- IU_AU, Op, ChainCount and Error are registered levels.
- Event priority within one tick: ClearEntry > Start > Enter > OpReq. Only the highest-priority event acts. Among simultaneous OpReq bits, the lowest index wins.
- FSM:
  - IDLE: go to GET_A unconditionally the next cycle.
  - GET_A: Enter -> pulse LoadA and LoadOU; IU_AU=0; go to GET_OP.
  - GET_OP: OpReq[i] -> Op=i; go to GET_B. ClearEntry -> GET_A.
  - GET_B: Enter -> pulse LoadB and LoadOU; go to WAIT_START. ClearEntry -> stay in GET_B.
  - WAIT_START, Start with Op==DIV_OP and DivZero=1 -> Error=1; go to ERR; no load pulses.
  - WAIT_START, Start otherwise -> go to EXEC.
  - WAIT_START, ClearEntry -> GET_B.
  - EXEC (exactly one cycle): pulse LoadResult; IU_AU=1; ChainCount+1; go to SHOW.
  - SHOW entry: pulse LoadOU once, the cycle after EXEC.
  - SHOW, OpReq[i] with ChainCount<MAX_CHAIN -> pulse LoadA with ResultToA; Op=i; IU_AU=0; go to GET_B.
  - SHOW, OpReq with ChainCount==MAX_CHAIN -> ignored.
  - SHOW, Enter or ClearEntry -> ChainCount=0; IU_AU=0; go to GET_A.
  - ERR: all strobes 0; IU_AU=0. ClearEntry or Enter -> Error=0, ChainCount=0; go to GET_A. Op, Start and OpReq are ignored.
- Events arriving in a state that does not consume them are dropped, not queued.
- Op holds its value until the next operator selection; it is not cleared by ClearEntry.

Decomposition:
- Package calc_ctrl_pkg:
  - state enum (IDLE, GET_A, GET_OP, GET_B, WAIT_START, EXEC, SHOW, ERR);
  - opcode localparams OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3.
- One sub-module, btn_event: parameter W. Contains the shared tick counter and the per-button sample and edge registers, and outputs an event vector. Instantiate it once for all NUM_OPS+3 buttons.

Test Plan (bench sets TICK_DIV=4; each button is held at least 2 ticks):
- Reset, then Enter, OpReq[0], Enter, Start -> LoadA, LoadOU, LoadB, LoadOU each one cycle; LoadResult pulse; Op=0; IU_AU=1; ChainCount=1; LoadOU pulse the cycle after LoadResult.
- Chain: after the above, OpReq[2], Enter, Start -> LoadA and ResultToA together in one cycle; Op=2; ChainCount=2. With MAX_CHAIN=2 a further OpReq gives no pulses and state stays SHOW.
- Op=3 with DivZero=1, then Start -> Error=1, no LoadResult. Start pressed again gives nothing. ClearEntry -> Error=0, state GET_A, ChainCount=0.
- ClearEntry and Enter in the same tick during GET_B -> no LoadB, state stays GET_B. OpReq=4'b1010 in GET_OP -> Op=1.
- Enter held 20 cycles -> exactly one LoadA.
- ClearAll=0 for one edge during WAIT_START -> all outputs 0 the next cycle, state IDLE, then GET_A.
- ClearAll deasserted asynchronously mid-cycle has no effect until the next Clock edge.
